// File: rtl/day07_sequencer.sv
// Input sequencer for the day-07 grid solver: clears the solver, measures the first
// row pitch, streams the grid bytes with one-cycle registered forwarding, then latches results.
module day07_sequencer #(
    parameter int CLEAR_CYCLES = 2,
    parameter int DRAIN_CYCLES = 4,
    parameter int MAX_WIDTH    = 4095
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic [63:0] sol_part1,
    input  logic [63:0] sol_part2,
    output logic [7:0]  sol_data,
    output logic        sol_valid,
    output logic        sol_clear,
    output logic [11:0] line_width,
    output logic [15:0] row_count,
    output logic [63:0] part1,
    output logic [63:0] part2,
    output logic        done_,
    output logic        error
);

    typedef enum logic [2:0] {
        CLR,
        MEASURE,
        STREAM,
        DRAIN,
        DONE,
        ERR
    } state_t;

    localparam logic [7:0] CHAR_EOT = 8'h04;
    localparam logic [7:0] CHAR_LF  = 8'h0A;
    localparam logic [7:0] CHAR_CR  = 8'h0D;

    state_t      r_state, w_state_nxt;
    logic [15:0] r_cnt, w_cnt_nxt;
    logic [11:0] r_col, w_col_nxt;
    logic [11:0] r_line_width, w_line_width_nxt;
    logic [15:0] r_row_count, w_row_count_nxt;
    logic [7:0]  r_sol_data, w_sol_data_nxt;
    logic        r_sol_valid, w_sol_valid_nxt;
    logic [63:0] r_part1, w_part1_nxt;
    logic [63:0] r_part2, w_part2_nxt;
    logic        r_error, w_error_nxt;

    logic        w_rx;
    logic        w_is_lf;
    logic        w_is_eot;
    logic [12:0] w_col_inc;
    logic        w_too_wide;
    logic        w_row_ok;
    logic [15:0] w_row_inc;

    // CR is dropped before any state sees it, so it can never count, forward or overrun.
    assign w_rx       = rx_valid && (rx_data != CHAR_CR);
    assign w_is_lf    = (rx_data == CHAR_LF);
    assign w_is_eot   = (rx_data == CHAR_EOT);
    assign w_col_inc  = {1'b0, r_col} + 13'd1;
    assign w_too_wide = (w_col_inc > 13'(MAX_WIDTH - 1));
    assign w_row_ok   = (r_col == r_line_width - 12'd1);
    assign w_row_inc  = (r_row_count == 16'hFFFF) ? r_row_count : r_row_count + 16'd1;

    // NOTE: every next-state value gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_col_nxt        = r_col;
        w_line_width_nxt = r_line_width;
        w_row_count_nxt  = r_row_count;
        w_sol_data_nxt   = r_sol_data;
        w_sol_valid_nxt  = 1'b0;
        w_part1_nxt      = r_part1;
        w_part2_nxt      = r_part2;
        w_error_nxt      = r_error;

        unique case (r_state)
            CLR: begin
                if (w_rx) begin
                    w_state_nxt = ERR;
                    w_error_nxt = 1'b1;
                end else if (r_cnt == 16'(CLEAR_CYCLES - 1)) begin
                    w_state_nxt = MEASURE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end

            MEASURE: begin
                if (w_rx) begin
                    if (w_is_eot || (w_is_lf && r_col == '0) || (!w_is_lf && w_too_wide)) begin
                        w_state_nxt = ERR;
                        w_error_nxt = 1'b1;
                    end else begin
                        w_sol_data_nxt  = rx_data;
                        w_sol_valid_nxt = 1'b1;
                        if (w_is_lf) begin
                            w_line_width_nxt = w_col_inc[11:0];
                            w_row_count_nxt  = w_row_inc;
                            w_col_nxt        = '0;
                            w_state_nxt      = STREAM;
                        end else begin
                            w_col_nxt = w_col_inc[11:0];
                        end
                    end
                end
            end

            STREAM: begin
                if (w_rx) begin
                    if (w_is_eot || (w_is_lf && r_col == '0)) begin
                        // An unterminated last row still counts and is width-checked.
                        if (r_col != '0) begin
                            w_row_count_nxt = w_row_inc;
                            if (!w_row_ok) w_error_nxt = 1'b1;
                        end
                        w_col_nxt   = '0;
                        w_cnt_nxt   = '0;
                        w_state_nxt = DRAIN;
                    end else begin
                        w_sol_data_nxt  = rx_data;
                        w_sol_valid_nxt = 1'b1;
                        if (w_is_lf) begin
                            w_row_count_nxt = w_row_inc;
                            w_col_nxt       = '0;
                            if (!w_row_ok) w_error_nxt = 1'b1;
                        end else if (!w_too_wide) begin
                            w_col_nxt = w_col_inc[11:0];
                        end
                    end
                end
            end

            DRAIN: begin
                if (r_cnt == 16'(DRAIN_CYCLES - 1)) begin
                    w_part1_nxt = sol_part1;
                    w_part2_nxt = sol_part2;
                    w_state_nxt = DONE;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end

            DONE: ;

            ERR: begin
                w_error_nxt = 1'b1;
                w_part1_nxt = '0;
                w_part2_nxt = '0;
            end

            default: begin
                w_state_nxt = ERR;
                w_error_nxt = 1'b1;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_state      <= CLR;
            r_cnt        <= '0;
            r_col        <= '0;
            r_line_width <= '0;
            r_row_count  <= '0;
            r_sol_data   <= '0;
            r_sol_valid  <= 1'b0;
            r_part1      <= '0;
            r_part2      <= '0;
            r_error      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_col        <= w_col_nxt;
            r_line_width <= w_line_width_nxt;
            r_row_count  <= w_row_count_nxt;
            r_sol_data   <= w_sol_data_nxt;
            r_sol_valid  <= w_sol_valid_nxt;
            r_part1      <= w_part1_nxt;
            r_part2      <= w_part2_nxt;
            r_error      <= w_error_nxt;
        end
    end

    assign sol_data   = r_sol_data;
    assign sol_valid  = r_sol_valid;
    assign sol_clear  = (r_state == CLR);
    assign line_width = r_line_width;
    assign row_count  = r_row_count;
    assign part1      = r_part1;
    assign part2      = r_part2;
    assign done_      = (r_state == DONE) || (r_state == ERR);
    assign error      = r_error;

endmodule

// File: tb/tb_day07_sequencer.sv
// Directed self-checking bench for day07_sequencer; inputs change and outputs are
// sampled on the falling clock edge.
module tb_day07_sequencer;

    logic        clock;
    logic        clear;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [63:0] sol_part1;
    logic [63:0] sol_part2;
    logic [7:0]  sol_data;
    logic        sol_valid;
    logic        sol_clear;
    logic [11:0] line_width;
    logic [15:0] row_count;
    logic [63:0] part1;
    logic [63:0] part2;
    logic        done_;
    logic        error;

    int checks = 0;
    int errors = 0;

    day07_sequencer dut (
        .clock      (clock),
        .clear      (clear),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .sol_part1  (sol_part1),
        .sol_part2  (sol_part2),
        .sol_data   (sol_data),
        .sol_valid  (sol_valid),
        .sol_clear  (sol_clear),
        .line_width (line_width),
        .row_count  (row_count),
        .part1      (part1),
        .part2      (part2),
        .done_      (done_),
        .error      (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    // One byte presented for one clock; returns at the next falling edge.
    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clock);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic send_fwd(input string tag, input logic [7:0] b);
        send(b);
        check({tag, " valid"}, sol_valid, 1'b1);
        check({tag, " data"}, sol_data, b);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
    endtask

    initial begin
        clear     = 1'b1;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        sol_part1 = 64'd5;
        sol_part2 = 64'd9;

        // Reset state
        tick(2);
        check("rst sol_clear", sol_clear, 1'b1);
        check("rst sol_valid", sol_valid, 1'b0);
        check("rst line_width", line_width, 12'd0);
        check("rst row_count", row_count, 16'd0);
        check("rst done", done_, 1'b0);
        check("rst error", error, 1'b0);
        clear = 1'b0;
        #1 check("clr cycle0", sol_clear, 1'b1);
        tick(1);
        check("clr cycle1", sol_clear, 1'b1);
        tick(1);
        check("clr cycle2 low", sol_clear, 1'b0);
        tick(10);
        check("idle sol_clear", sol_clear, 1'b0);
        check("idle done", done_, 1'b0);

        // "ab\nab\n\n"
        send_fwd("t2 a0", "a");
        send_fwd("t2 b0", "b");
        send_fwd("t2 lf0", 8'h0A);
        send_fwd("t2 a1", "a");
        send_fwd("t2 b1", "b");
        send_fwd("t2 lf1", 8'h0A);
        send(8'h0A);
        check("t2 blank not fwd", sol_valid, 1'b0);
        tick(3);
        check("t2 done early", done_, 1'b0);
        tick(1);
        check("t2 done", done_, 1'b1);
        check("t2 line_width", line_width, 12'd3);
        check("t2 row_count", row_count, 16'd2);
        check("t2 part1", part1, 64'd5);
        check("t2 part2", part2, 64'd9);
        check("t2 error", error, 1'b0);
        send("z");
        check("t2 frozen valid", sol_valid, 1'b0);
        check("t2 frozen rows", row_count, 16'd2);
        check("t2 frozen done", done_, 1'b1);

        // "abc\r\nabc\r\n" EOT
        pulse_clear();
        tick(2);
        send_fwd("t3 a0", "a");
        send_fwd("t3 b0", "b");
        send_fwd("t3 c0", "c");
        send(8'h0D);
        check("t3 cr0 dropped", sol_valid, 1'b0);
        send_fwd("t3 lf0", 8'h0A);
        send("a");
        send("b");
        send("c");
        send(8'h0D);
        check("t3 cr1 dropped", sol_valid, 1'b0);
        send(8'h0A);
        send(8'h04);
        check("t3 eot not fwd", sol_valid, 1'b0);
        tick(4);
        check("t3 done", done_, 1'b1);
        check("t3 line_width", line_width, 12'd4);
        check("t3 row_count", row_count, 16'd2);
        check("t3 error", error, 1'b0);

        // "abc\nab\nabc" EOT: short middle row, unterminated last row
        sol_part1 = 64'h1234_5678_9abc_def0;
        sol_part2 = 64'hffff_0000_1111_2222;
        pulse_clear();
        tick(2);
        send("a"); send("b"); send("c"); send(8'h0A);
        send("a"); send("b"); send(8'h0A);
        check("t4 sticky error", error, 1'b1);
        check("t4 continues done", done_, 1'b0);
        send("a"); send("b"); send("c"); send(8'h04);
        tick(4);
        check("t4 row_count", row_count, 16'd3);
        check("t4 error", error, 1'b1);
        check("t4 done", done_, 1'b1);
        check("t4 part1", part1, 64'h1234_5678_9abc_def0);
        check("t4 part2", part2, 64'hffff_0000_1111_2222);

        // rx_valid during CLR -> ERR
        pulse_clear();
        send("a");
        check("t5 clr done", done_, 1'b1);
        check("t5 clr error", error, 1'b1);
        check("t5 clr part1", part1, 64'd0);
        check("t5 clr valid", sol_valid, 1'b0);
        tick(3);
        check("t5 clr hold", done_ & error, 1'b1);

        // First byte LF -> ERR
        pulse_clear();
        tick(2);
        send(8'h0A);
        check("t5 lf done", done_, 1'b1);
        check("t5 lf error", error, 1'b1);
        check("t5 lf part1", part1, 64'd0);
        check("t5 lf valid", sol_valid, 1'b0);

        // Async clear mid-STREAM, then a fresh run
        sol_part1 = 64'd77;
        sol_part2 = 64'd88;
        pulse_clear();
        tick(2);
        send("a"); send("b"); send(8'h0A);
        send_fwd("t6 pre", "a");
        #2 clear = 1'b1;
        #1;
        check("t6 sol_clear", sol_clear, 1'b1);
        check("t6 sol_valid", sol_valid, 1'b0);
        check("t6 sol_data", sol_data, 8'h00);
        check("t6 line_width", line_width, 12'd0);
        check("t6 row_count", row_count, 16'd0);
        check("t6 part1", part1, 64'd0);
        check("t6 done", done_, 1'b0);
        check("t6 error", error, 1'b0);
        tick(1);
        clear = 1'b0;
        tick(2);
        send("x"); send("y"); send(8'h0A);
        send("x"); send("y"); send(8'h0A);
        send(8'h0A);
        tick(4);
        check("t6 run done", done_, 1'b1);
        check("t6 run width", line_width, 12'd3);
        check("t6 run rows", row_count, 16'd2);
        check("t6 run part1", part1, 64'd77);
        check("t6 run part2", part2, 64'd88);
        check("t6 run error", error, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
